// File: rtl/psum_writeback_if.sv
// psum_writeback_if
//   Bundles the OFIFO pop port and the single-port psum SRAM port of the
//   corelet writeback path.
//   master : the writeback engine (pops the OFIFO, drives the SRAM)
//   slave  : the OFIFO + SRAM side
//   Signals:
//     ofifo_valid  OFIFO holds at least one row
//     ofifo_rd     OFIFO pop strobe
//     ofifo_data   OFIFO head row, valid the cycle after ofifo_rd
//     sram_cen     SRAM enable, active-high
//     sram_wen     1 = write, 0 = read
//     sram_addr    SRAM row address
//     sram_din     SRAM write data
//     sram_dout    SRAM read data, valid 1 cycle after a read
interface psum_writeback_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
);
  logic                     ofifo_valid;
  logic                     ofifo_rd;
  logic [col*psum_bw-1:0]   ofifo_data;
  logic                     sram_cen;
  logic                     sram_wen;
  logic [addr_bw-1:0]       sram_addr;
  logic [col*psum_bw-1:0]   sram_din;
  logic [col*psum_bw-1:0]   sram_dout;

  modport master (
    input  ofifo_valid, ofifo_data, sram_dout,
    output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_din
  );

  modport slave (
    output ofifo_valid, ofifo_data, sram_dout,
    input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_din
  );
endinterface

// File: rtl/psum_writeback.sv
// psum_writeback
//   Consumer end of the corelet OFIFO. Pops one row of col x psum_bw partial
//   sums per transfer and writes it to the psum SRAM at an incrementing
//   address, optionally adding it to the existing SRAM row first.
//   Optional feature macro: PSUM_RELU_EN (clamp negative lanes to 0 on write
//   when relu was set at start). Undefined: data is written unchanged.
//   Ports:
//     clk, reset   clock / synchronous active-high reset
//     start        1-cycle pulse, accepted only in IDLE
//     acc_en       sampled at start: accumulate into SRAM (1) or overwrite (0)
//     relu         sampled at start: ReLU on written data (PSUM_RELU_EN only)
//     base_addr    sampled at start: first SRAM row address
//     num_rows     sampled at start: rows to transfer (0 is legal)
//     bus          OFIFO + SRAM port (psum_writeback_if.master)
//     busy         high in every state except IDLE
//     done         1-cycle pulse when the transfer completes
//
// state | meaning
// IDLE  | waiting for start
// POP   | pop the OFIFO head row when one is available
// CAP   | capture the popped row; issue SRAM read when accumulating
// ACC   | add SRAM read data to the captured row lane by lane
// WR    | write the row to SRAM, advance address and row count
// DONE  | one-cycle completion pulse
module psum_writeback #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               acc_en,
  input  logic               relu,
  input  logic [addr_bw-1:0] base_addr,
  input  logic [addr_bw-1:0] num_rows,
  psum_writeback_if.master   bus,
  output logic               busy,
  output logic               done
);
  localparam int W = col * psum_bw;

  typedef enum logic [2:0] {IDLE, POP, CAP, ACC, WR, DONE} state_t;

  state_t             state, next_state;
  logic               acc_q;
  logic               rd_q;
  logic [addr_bw-1:0] num_rows_q;
  logic [addr_bw-1:0] cur_addr;
  logic [addr_bw-1:0] row_cnt;
  logic [W-1:0]       data_reg;
  logic [W-1:0]       acc_sum;
  logic [W-1:0]       wr_data;
  logic               last_row;

  assign last_row = (row_cnt == (num_rows_q - addr_bw'(1)));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.ofifo_rd  = rd_q;
    bus.sram_cen  = 1'b0;
    bus.sram_wen  = 1'b0;
    bus.sram_addr = cur_addr;
    bus.sram_din  = wr_data;
    busy          = (state != IDLE);
    done          = 1'b0;
    case (state)
      IDLE: if (start) next_state = (num_rows == '0) ? DONE : POP;
      POP:  if (rd_q) next_state = CAP;
      CAP: begin
        bus.sram_cen = acc_q;
        next_state   = acc_q ? ACC : WR;
      end
      ACC:  next_state = WR;
      WR: begin
        bus.sram_cen = 1'b1;
        bus.sram_wen = 1'b1;
        next_state   = last_row ? DONE : POP;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Lane-wise add with natural psum_bw wraparound.
  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < col; i++)
      acc_sum[i*psum_bw +: psum_bw] = data_reg[i*psum_bw +: psum_bw] + bus.sram_dout[i*psum_bw +: psum_bw];
  end

`ifdef PSUM_RELU_EN
  logic relu_q;

  always_ff @(posedge clk) begin
    if (reset)                      relu_q <= 1'b0;
    else if (state == IDLE && start) relu_q <= relu;
  end

  always_comb begin
    wr_data = data_reg;
    for (int i = 0; i < col; i++)
      if (relu_q && data_reg[i*psum_bw + psum_bw - 1])
        wr_data[i*psum_bw +: psum_bw] = '0;
  end
`else
  logic unused_relu;
  assign unused_relu = relu;
  assign wr_data     = data_reg;
`endif

  // The pop strobe is registered so ofifo_valid never reaches ofifo_rd
  // combinationally: valid is looked at in the cycle before (and while) the
  // FSM sits in POP. Only this block pops the OFIFO, so a row seen one cycle
  // early is still there when the strobe fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q       <= 1'b0;
      acc_q      <= 1'b0;
      num_rows_q <= '0;
      cur_addr   <= '0;
      row_cnt    <= '0;
      data_reg   <= '0;
    end else begin
      rd_q <= (next_state == POP) && bus.ofifo_valid;
      case (state)
        IDLE: if (start) begin
          acc_q      <= acc_en;
          num_rows_q <= num_rows;
          cur_addr   <= base_addr;
          row_cnt    <= '0;
        end
        CAP: data_reg <= bus.ofifo_data;
        ACC: data_reg <= acc_sum;
        WR: begin
          cur_addr <= cur_addr + addr_bw'(1);
          row_cnt  <= row_cnt + addr_bw'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_writeback.sv
module tb_psum_writeback;
  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int ABW = 11;
  localparam int W   = COL * PBW;

  typedef struct {
    logic [ABW-1:0] addr;
    logic [W-1:0]   data;
  } wr_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           acc_en = 1'b0;
  logic           relu = 1'b0;
  logic [ABW-1:0] base_addr = '0;
  logic [ABW-1:0] num_rows = '0;
  logic           busy, done;

  psum_writeback_if #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) bus ();

  psum_writeback #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) dut (
    .clk(clk), .reset(reset), .start(start), .acc_en(acc_en), .relu(relu),
    .base_addr(base_addr), .num_rows(num_rows), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int rd_seen = 0, srd_seen = 0, swr_seen = 0, done_cnt = 0;
  int wr_cyc = 0, done_cyc = 0, read_cyc = 0;

  wr_t        exp_q[$];
  logic [W-1:0] fifo_q[$];
  logic       fifo_en = 1'b1;
  logic [W-1:0] mem [0:(1<<ABW)-1];
  logic       pre_en = 1'b0;
  logic [ABW-1:0] pre_addr = '0;
  logic [W-1:0]   pre_data = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // OFIFO model: pop on ofifo_rd, head presented the following cycle.
  always @(posedge clk) begin
    if (bus.ofifo_rd && fifo_q.size() != 0) bus.ofifo_data <= fifo_q.pop_front();
  end
  always @(negedge clk) bus.ofifo_valid <= fifo_en && (fifo_q.size() != 0);

  // SRAM model with a preload side door for the stimulus.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.sram_cen) begin
      if (bus.sram_wen) mem[bus.sram_addr] <= bus.sram_din;
      else              bus.sram_dout <= mem[bus.sram_addr];
    end
  end

  // Monitor: compare every SRAM write against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ofifo_rd) rd_seen++;
      if (bus.sram_cen && !bus.sram_wen) begin
        srd_seen++;
        read_cyc = cyc;
      end
      if (bus.sram_cen && bus.sram_wen) begin
        swr_seen++;
        wr_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_write", W'(bus.sram_addr), '1);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", W'(bus.sram_addr), W'(e.addr));
          check("wr_data", bus.sram_din, e.data);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic expect_wr(input logic [ABW-1:0] a, input logic [W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic preload(input logic [ABW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic start_xfer(input logic acc, input logic rl, input logic [ABW-1:0] base, input logic [ABW-1:0] n);
    @(negedge clk);
    acc_en = acc; relu = rl; base_addr = base; num_rows = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int bcnt);
    bit seen;
    seen = 0;
    bcnt = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (busy) bcnt++;
      if (done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) check({name, "_done_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  localparam logic [W-1:0] R1 = 128'h1117_1116_1115_1114_1113_1112_1111_1110;
  localparam logic [W-1:0] R2 = 128'h2227_2226_2225_2224_2223_2222_2221_2220;
  localparam logic [W-1:0] R3 = 128'h3337_3336_3335_3334_3333_3332_3331_3330;
  localparam logic [W-1:0] M2 = 128'h0070_0060_0050_0040_0030_0020_0100_0005;
  localparam logic [W-1:0] F2 = 128'h0007_0006_0005_0004_0003_0002_0001_FFFE;
  localparam logic [W-1:0] E2 = 128'h0077_0066_0055_0044_0033_0022_0101_0003;
  localparam logic [W-1:0] M3A = 128'h8000_0000_0000_0000_0000_0000_0000_7FFF;
  localparam logic [W-1:0] F3A = 128'hFFFF_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [W-1:0] E3A = 128'h7FFF_0000_0000_0000_0000_0000_0000_8000;
  localparam logic [W-1:0] M3B = 128'h0000_0000_0000_0000_0000_0000_0000_0010;
  localparam logic [W-1:0] F3B = 128'h0000_0000_0000_0000_0000_0000_0000_0020;
  localparam logic [W-1:0] E3B = 128'h0000_0000_0000_0000_0000_0000_0000_0030;
  localparam logic [W-1:0] R4 = 128'hABCD_0123_4567_89AB_CDEF_FEDC_BA98_7654;
  localparam logic [W-1:0] F6 = 128'h0000_0000_0000_0000_0000_0000_0012_FFF0;
`ifdef PSUM_RELU_EN
  localparam logic [W-1:0] E6 = 128'h0000_0000_0000_0000_0000_0000_0012_0000;
`else
  localparam logic [W-1:0] E6 = 128'h0000_0000_0000_0000_0000_0000_0012_FFF0;
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, r0, w0, s0, d0;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl", W'({bus.ofifo_rd, bus.sram_cen, bus.sram_wen, busy, done}), 0);
    check("rst_addr", W'(bus.sram_addr), 0);
    check("rst_din", bus.sram_din, 0);
    reset = 1'b0;

    // 1: overwrite, three rows
    fifo_q.push_back(R1); fifo_q.push_back(R2); fifo_q.push_back(R3);
    expect_wr(11'h010, R1); expect_wr(11'h011, R2); expect_wr(11'h012, R3);
    start_xfer(1'b0, 1'b0, 11'h010, 11'd3);
    wait_done("t1", bc);
    check("t1_busy_cycles", W'(bc), 10);
    check("t1_done_after_last_wr", W'(done_cyc), W'(wr_cyc + 1));
    check("t1_drained", W'(exp_q.size()), 0);

    // 2: accumulate, one SRAM read before the write
    preload(11'h020, M2);
    fifo_q.push_back(F2);
    expect_wr(11'h020, E2);
    s0 = srd_seen;
    start_xfer(1'b1, 1'b0, 11'h020, 11'd1);
    wait_done("t2", bc);
    check("t2_reads", W'(srd_seen - s0), 1);
    check("t2_read_before_wr", W'(read_cyc + 2), W'(wr_cyc));
    check("t2_sram_row", mem[11'h020], E2);

    // 3: lane wrap and address wrap
    preload(11'h7FF, M3A);
    preload(11'h000, M3B);
    fifo_q.push_back(F3A); fifo_q.push_back(F3B);
    expect_wr(11'h7FF, E3A); expect_wr(11'h000, E3B);
    start_xfer(1'b1, 1'b0, 11'h7FF, 11'd2);
    wait_done("t3", bc);
    check("t3_drained", W'(exp_q.size()), 0);

    // 4: OFIFO stall in POP
    fifo_en = 1'b0;
    fifo_q.push_back(R4);
    expect_wr(11'h040, R4);
    start_xfer(1'b0, 1'b0, 11'h040, 11'd1);
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_quiet", W'({bus.ofifo_rd, bus.sram_cen, busy}), W'(3'b001));
      @(negedge clk);
    end
    fifo_en = 1'b1;
    wait_done("t4", bc);
    check("t4_drained", W'(exp_q.size()), 0);

    // 5a: zero rows
    r0 = rd_seen; s0 = srd_seen; w0 = swr_seen;
    start_xfer(1'b0, 1'b0, 11'h100, 11'd0);
    wait_done("t5a", bc);
    check("t5a_busy_cycles", W'(bc), 1);
    check("t5a_no_activity", W'((rd_seen - r0) + (srd_seen - s0) + (swr_seen - w0)), 0);

    // 5b: reset while in ACC
    preload(11'h050, M2);
    fifo_q.push_back(F2); fifo_q.push_back(F2);
    d0 = done_cnt; w0 = swr_seen;
    start_xfer(1'b1, 1'b0, 11'h050, 11'd2);
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
        if (bus.sram_cen && !bus.sram_wen) hit = 1;
        else @(negedge clk);
      end
      if (!hit) check("t5b_read_timeout", 0, 1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5b_ctrl_zero", W'({bus.ofifo_rd, bus.sram_cen, bus.sram_wen, busy, done}), 0);
    check("t5b_addr_zero", W'(bus.sram_addr), 0);
    check("t5b_din_zero", bus.sram_din, 0);
    reset = 1'b0;
    fifo_q.delete();
    repeat (5) @(negedge clk);
    check("t5b_no_done", W'(done_cnt - d0), 0);
    check("t5b_no_write", W'(swr_seen - w0), 0);
    check("t5b_sram_untouched", mem[11'h050], M2);

    // 6: ReLU on write
    fifo_q.push_back(F6);
    expect_wr(11'h100, E6);
    start_xfer(1'b0, 1'b1, 11'h100, 11'd1);
    wait_done("t6", bc);
    check("t6_drained", W'(exp_q.size()), 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
